// File: rtl/hba_pkg.sv
// Shared HBA definitions: bus widths, arbiter state encoding, width helpers.
package hba_pkg;

   localparam int unsigned HBA_ABUS_W = 12;
   localparam int unsigned HBA_DBUS_W = 8;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StGrant   = 2'd1,
      StRelease = 2'd2
   } arb_state_e;

   // Width of a master index; never narrower than one bit.
   function automatic int unsigned owner_w(input int unsigned num_masters);
      return (num_masters <= 2) ? 1 : $clog2(num_masters);
   endfunction

   // Width of a counter that must hold values 0..max_val inclusive.
   function automatic int unsigned cnt_w(input int unsigned max_val);
      return (max_val == 0) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/hba_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module hba_rr_pick
   import hba_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = 2,
   parameter int unsigned OWNER_W     = owner_w(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req_i,
   input  logic [OWNER_W-1:0]     ptr_i,
   output logic [OWNER_W-1:0]     sel_o,
   output logic                   valid_o
);

   int unsigned        idx;
   logic [OWNER_W-1:0] cand;

   // Walk offsets 0..N-1 from the pointer; the first hit wins.
   always_comb begin
      sel_o   = '0;
      valid_o = 1'b0;
      idx     = 0;
      cand    = '0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         idx = 32'(ptr_i) + i;
         if (idx >= NUM_MASTERS) begin
            idx = idx - NUM_MASTERS;
         end
         cand = OWNER_W'(idx);
         if (!valid_o && req_i[cand]) begin
            valid_o = 1'b1;
            sel_o   = cand;
         end
      end
   end

endmodule

// File: rtl/hba_master_arbiter.sv
// Round-robin HBA bus master arbiter with per-grant transfer quota.
// Optional grant watchdog enabled by defining HBA_ARB_TIMEOUT_EN.
module hba_master_arbiter
   import hba_pkg::*;
#(
   parameter int unsigned NUM_MASTERS    = 2,
   parameter int unsigned MAX_XFERS      = 8,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned OWNER_W        = owner_w(NUM_MASTERS)
) (
   input  logic                   hba_clk,
   input  logic                   hba_reset,
   input  logic [NUM_MASTERS-1:0] master_request,
   input  logic                   hba_xferack,
   output logic [NUM_MASTERS-1:0] hba_mgrant,
   output logic [OWNER_W-1:0]     arb_owner,
   output logic                   arb_busy,
   output logic                   arb_timeout
);

   localparam int unsigned XferW = cnt_w(MAX_XFERS);
   // Count value on which the final permitted xferack arrives.
   localparam logic [XferW-1:0] QuotaLast =
      (MAX_XFERS == 0) ? '0 : XferW'(MAX_XFERS - 1);
   // Saturation point; with no quota the counter just pins at all-ones.
   localparam logic [XferW-1:0] XferSat =
      (MAX_XFERS == 0) ? '1 : XferW'(MAX_XFERS);
   localparam logic [OWNER_W-1:0] LastIdx = OWNER_W'(NUM_MASTERS - 1);

   arb_state_e             state_q, state_d;
   logic [NUM_MASTERS-1:0] mgrant_q, mgrant_d;
   logic [OWNER_W-1:0]     owner_q, owner_d;
   logic                   busy_q, busy_d;
   logic                   timeout_q, timeout_d;
   logic [OWNER_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [XferW-1:0]       xfer_cnt_q, xfer_cnt_d;

   logic [OWNER_W-1:0]     pick_sel;
   logic                   pick_valid;
   logic                   rel_drop;
   logic                   rel_quota;
   logic                   tmo_hit;

   hba_rr_pick #(
      .NUM_MASTERS (NUM_MASTERS),
      .OWNER_W     (OWNER_W)
   ) u_pick (
      .req_i   (master_request),
      .ptr_i   (rr_ptr_q),
      .sel_o   (pick_sel),
      .valid_o (pick_valid)
   );

`ifdef HBA_ARB_TIMEOUT_EN
   localparam int unsigned WaitW = cnt_w(TIMEOUT_CYCLES);
   localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT_CYCLES - 1);

   logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;

   // Idle-wait counter: held at zero outside GRANT, cleared by every xferack.
   always_comb begin
      wait_cnt_d = '0;
      tmo_hit    = 1'b0;
      if (state_q == StGrant) begin
         if (hba_xferack) begin
            wait_cnt_d = '0;
         end else begin
            wait_cnt_d = wait_cnt_q + WaitW'(1);
            // This edge brings the count to TIMEOUT_CYCLES.
            tmo_hit    = (wait_cnt_q == WaitLast);
         end
      end
   end

   // Wait counter register.
   always_ff @(posedge hba_clk) begin
      if (hba_reset) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // Release conditions evaluated while a grant is active.
   always_comb begin
      rel_drop  = ~master_request[owner_q];
      rel_quota = (MAX_XFERS != 0) && hba_xferack && (xfer_cnt_q == QuotaLast);
   end

   // Next-state and registered-output logic for the arbiter FSM.
   always_comb begin
      state_d    = state_q;
      mgrant_d   = mgrant_q;
      owner_d    = owner_q;
      busy_d     = busy_q;
      timeout_d  = 1'b0;
      rr_ptr_d   = rr_ptr_q;
      xfer_cnt_d = xfer_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (pick_valid) begin
               mgrant_d           = '0;
               mgrant_d[pick_sel] = 1'b1;
               owner_d            = pick_sel;
               busy_d             = 1'b1;
               xfer_cnt_d         = '0;
               state_d            = StGrant;
            end
         end
         StGrant: begin
            if (hba_xferack && (xfer_cnt_q != XferSat)) begin
               xfer_cnt_d = xfer_cnt_q + XferW'(1);
            end
            if (rel_drop || rel_quota || tmo_hit) begin
               mgrant_d  = '0;
               busy_d    = 1'b0;
               // Watchdog pulse only when nothing else ended the grant.
               timeout_d = tmo_hit && !rel_drop && !rel_quota;
               // Last owner drops to lowest priority.
               rr_ptr_d  = (owner_q == LastIdx) ? '0 : owner_q + OWNER_W'(1);
               state_d   = StRelease;
            end
         end
         StRelease: begin
            state_d = StIdle;
         end
         default: begin
            mgrant_d = '0;
            busy_d   = 1'b0;
            state_d  = StIdle;
         end
      endcase
   end

   // Arbiter state and output registers.
   always_ff @(posedge hba_clk) begin
      if (hba_reset) begin
         state_q    <= StIdle;
         mgrant_q   <= '0;
         owner_q    <= '0;
         busy_q     <= 1'b0;
         timeout_q  <= 1'b0;
         rr_ptr_q   <= '0;
         xfer_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         mgrant_q   <= mgrant_d;
         owner_q    <= owner_d;
         busy_q     <= busy_d;
         timeout_q  <= timeout_d;
         rr_ptr_q   <= rr_ptr_d;
         xfer_cnt_q <= xfer_cnt_d;
      end
   end

   assign hba_mgrant  = mgrant_q;
   assign arb_owner   = owner_q;
   assign arb_busy    = busy_q;
   assign arb_timeout = timeout_q;

endmodule

// File: tb/tb_hba_master_arbiter.sv
// Directed bench for hba_master_arbiter: reset, handover, quota, reset mid-grant, timeout.
module tb_hba_master_arbiter;

   logic       clk;
   logic       hba_reset;
   logic [1:0] req;
   logic       ack;
   logic [1:0] mgrant;
   logic [0:0] owner;
   logic       busy;
   logic       tmo;

   logic [1:0] req2;
   logic       ack2;
   logic [1:0] mgrant2;
   logic [0:0] owner2;
   logic       busy2;
   logic       tmo2;

   int total = 0;
   int bad   = 0;

   hba_master_arbiter #(
      .NUM_MASTERS    (2),
      .MAX_XFERS      (8),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .hba_clk        (clk),
      .hba_reset      (hba_reset),
      .master_request (req),
      .hba_xferack    (ack),
      .hba_mgrant     (mgrant),
      .arb_owner      (owner),
      .arb_busy       (busy),
      .arb_timeout    (tmo)
   );

   // Second instance with a tiny quota for the sole-requester case.
   hba_master_arbiter #(
      .NUM_MASTERS    (2),
      .MAX_XFERS      (2),
      .TIMEOUT_CYCLES (16)
   ) dut_q2 (
      .hba_clk        (clk),
      .hba_reset      (hba_reset),
      .master_request (req2),
      .hba_xferack    (ack2),
      .hba_mgrant     (mgrant2),
      .arb_owner      (owner2),
      .arb_busy       (busy2),
      .arb_timeout    (tmo2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      hba_reset = 1'b1;
      req = 2'b00; ack = 1'b0; req2 = 2'b00; ack2 = 1'b0;
      tick(); tick(); tick();
      total++; if (mgrant !== 2'b00) begin bad++; $display("FAIL rst_mgrant got=%b exp=00", mgrant); end
      total++; if (owner !== 1'b0) begin bad++; $display("FAIL rst_owner got=%0d exp=0", owner); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
      total++; if (tmo !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b exp=0", tmo); end
      total++; if (mgrant2 !== 2'b00) begin bad++; $display("FAIL rst_mgrant2 got=%b exp=00", mgrant2); end
      hba_reset = 1'b0;
      req = 2'b01;
      tick();
      total++; if (mgrant !== 2'b01) begin bad++; $display("FAIL first_grant got=%b exp=01", mgrant); end
      total++; if (owner !== 1'b0) begin bad++; $display("FAIL first_owner got=%0d exp=0", owner); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL first_busy got=%b exp=1", busy); end
   endtask

   task automatic test_handover();
      req = 2'b11;
      ack = 1'b1;
      tick(); tick(); tick();
      total++; if (mgrant !== 2'b01) begin bad++; $display("FAIL ho_hold got=%b exp=01", mgrant); end
      ack = 1'b0;
      req = 2'b10;
      tick();
      total++; if (mgrant !== 2'b00) begin bad++; $display("FAIL ho_t1_grant got=%b exp=00", mgrant); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL ho_t1_busy got=%b exp=0", busy); end
      total++; if (owner !== 1'b0) begin bad++; $display("FAIL ho_t1_owner got=%0d exp=0", owner); end
      tick();
      total++; if (mgrant !== 2'b00) begin bad++; $display("FAIL ho_t2_grant got=%b exp=00", mgrant); end
      tick();
      total++; if (mgrant !== 2'b10) begin bad++; $display("FAIL ho_t3_grant got=%b exp=10", mgrant); end
      total++; if (owner !== 1'b1) begin bad++; $display("FAIL ho_t3_owner got=%0d exp=1", owner); end
      req = 2'b00;
      tick(); tick();
   endtask

   task automatic test_quota();
      req = 2'b11;
      tick();
      total++; if (mgrant !== 2'b01) begin bad++; $display("FAIL q_grant0 got=%b exp=01", mgrant); end
      ack = 1'b1;
      repeat (7) tick();
      total++; if (mgrant !== 2'b01) begin bad++; $display("FAIL q_after7 got=%b exp=01", mgrant); end
      tick();
      total++; if (mgrant !== 2'b00) begin bad++; $display("FAIL q_after8 got=%b exp=00", mgrant); end
      ack = 1'b0;
      tick();
      total++; if (mgrant !== 2'b00) begin bad++; $display("FAIL q_idle got=%b exp=00", mgrant); end
      tick();
      total++; if (mgrant !== 2'b10) begin bad++; $display("FAIL q_grant1 got=%b exp=10", mgrant); end
      total++; if (owner !== 1'b1) begin bad++; $display("FAIL q_owner1 got=%0d exp=1", owner); end
      repeat (3) tick();
      total++; if (mgrant !== 2'b10) begin bad++; $display("FAIL q_m1_hold got=%b exp=10", mgrant); end
      req = 2'b01;
      tick(); tick(); tick();
      total++; if (mgrant !== 2'b01) begin bad++; $display("FAIL q_m0_back got=%b exp=01", mgrant); end
      total++; if (owner !== 1'b0) begin bad++; $display("FAIL q_m0_owner got=%0d exp=0", owner); end
      req = 2'b00;
      tick(); tick();
   endtask

   task automatic test_quota_sole();
      logic exp_seq [6];
      exp_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      req2 = 2'b01;
      tick();
      total++; if (mgrant2 !== 2'b01) begin bad++; $display("FAIL sole_grant got=%b exp=01", mgrant2); end
      ack2 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         total++;
         if (mgrant2 !== {1'b0, exp_seq[i]}) begin
            bad++;
            $display("FAIL sole_seq[%0d] got=%b exp=0%b", i, mgrant2, exp_seq[i]);
         end
      end
      ack2 = 1'b0;
      req2 = 2'b00;
      tick(); tick();
   endtask

   task automatic test_reset_mid_grant();
      req = 2'b10;
      tick();
      total++; if (mgrant !== 2'b10) begin bad++; $display("FAIL rm_grant got=%b exp=10", mgrant); end
      ack = 1'b1;
      repeat (5) tick();
      ack = 1'b0;
      hba_reset = 1'b1;
      tick();
      total++; if (mgrant !== 2'b00) begin bad++; $display("FAIL rm_drop got=%b exp=00", mgrant); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b exp=0", busy); end
      total++; if (owner !== 1'b0) begin bad++; $display("FAIL rm_owner got=%0d exp=0", owner); end
      hba_reset = 1'b0;
      req = 2'b11;
      tick();
      total++; if (mgrant !== 2'b01) begin bad++; $display("FAIL rm_restart got=%b exp=01", mgrant); end
      req = 2'b00;
      tick(); tick();
   endtask

   task automatic test_timeout();
      int granted;
      int pulses;
      req = 2'b01;
      ack = 1'b0;
      tick();
      total++; if (mgrant !== 2'b01) begin bad++; $display("FAIL to_grant got=%b exp=01", mgrant); end
      granted = 1;
      pulses  = 0;
`ifdef HBA_ARB_TIMEOUT_EN
      for (int k = 0; k < 40; k++) begin
         tick();
         if (mgrant == 2'b01) granted++;
         if (tmo === 1'b1) begin
            pulses++;
            req = 2'b00;
         end
      end
      total++; if (granted != 16) begin bad++; $display("FAIL to_grant_cycles got=%0d exp=16", granted); end
      total++; if (pulses != 1) begin bad++; $display("FAIL to_pulses got=%0d exp=1", pulses); end
      req = 2'b11;
      tick();
      total++; if (mgrant !== 2'b10) begin bad++; $display("FAIL to_rotate got=%b exp=10", mgrant); end
      req = 2'b00;
      tick(); tick();
`else
      for (int k = 0; k < 1000; k++) begin
         tick();
         if (mgrant == 2'b01) granted++;
         if (tmo !== 1'b0) pulses++;
      end
      total++; if (granted != 1001) begin bad++; $display("FAIL to_persist got=%0d exp=1001", granted); end
      total++; if (pulses != 0) begin bad++; $display("FAIL to_pulses got=%0d exp=0", pulses); end
      req = 2'b00;
      tick();
      total++; if (mgrant !== 2'b00) begin bad++; $display("FAIL to_release got=%b exp=00", mgrant); end
      tick();
`endif
   endtask

   initial begin
      hba_reset = 1'b1;
      req = 2'b00; ack = 1'b0; req2 = 2'b00; ack2 = 1'b0;
      test_reset();
      test_handover();
      test_quota();
      test_quota_sole();
      test_reset_mid_grant();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Grant must never have more than one bit set.
   always @(negedge clk) begin
      if (!hba_reset && ($countones(mgrant) > 1 || $countones(mgrant2) > 1)) begin
         total++;
         bad++;
         $display("FAIL onehot got=%b/%b exp=onehot0", mgrant, mgrant2);
      end
   end

endmodule
